// File: rtl/button_toggle.sv
// button_toggle: debounced push-button toggle driving the 5/7 display select, with press pulse and press counter
module button_toggle #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_in,
  output logic       value,
  output logic       press_pulse,
  output logic [3:0] press_count
);
  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic s1, s2;
  // two-flop synchroniser for the asynchronous raw button
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {s1, s2} <= 2'b00;
    else {s1, s2} <= {btn_in, s1};
  // debounce fsm: a press is accepted only after DEBOUNCE_CYCLES stable high samples, and toggles once
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      value <= 1'b0;
      press_pulse <= 1'b0;
      press_count <= 4'd0;
    end else begin
      press_pulse <= 1'b0;
      case (state)
        IDLE:
          if (s2) begin
            state <= PRESS_WAIT;
            cnt <= '0;
          end
        PRESS_WAIT:
          if (!s2) begin
            state <= IDLE;
            cnt <= '0;
          end else if (cnt == LAST) begin
            state <= HELD;
            value <= ~value;
            press_pulse <= 1'b1;
            press_count <= press_count + 4'd1;
          end else cnt <= cnt + 1'b1;
        HELD:
          if (!s2) begin
            state <= RELEASE_WAIT;
            cnt <= '0;
          end
        RELEASE_WAIT:
          if (s2) begin
            state <= HELD;
            cnt <= '0;
          end else if (cnt == LAST) state <= IDLE;
          else cnt <= cnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_button_toggle.sv
// tb_button_toggle: scoreboard bench for button_toggle with N=4 and N=8 instances
module tb_button_toggle;
  logic clk = 1'b0;
  logic rst_n4 = 1'b1, rst_n8 = 1'b1, btn4 = 1'b0, btn8 = 1'b0;
  logic v4, p4, v8, p8;
  logic [3:0] c4, c8;
  int cyc = 0, vectors = 0, miscompares = 0, pulses4 = 0;
  typedef struct {int cyc; logic v; logic [3:0] c;} exp_t;
  exp_t exp4[$], exp8[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  button_toggle #(.DEBOUNCE_CYCLES(4), .CNT_W(4)) u4 (
    .clk(clk), .rst_n(rst_n4), .btn_in(btn4), .value(v4), .press_pulse(p4), .press_count(c4));
  button_toggle #(.DEBOUNCE_CYCLES(8), .CNT_W(4)) u8 (
    .clk(clk), .rst_n(rst_n8), .btn_in(btn8), .value(v8), .press_pulse(p8), .press_count(c8));

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (p4) begin
        vectors++;
        pulses4++;
        if (exp4.size() == 0) begin
          miscompares++;
          $display("FAIL pulse4_unexpected cycle=%0d value=%b count=%0d", cyc, v4, c4);
        end else begin
          e = exp4.pop_front();
          if (cyc !== e.cyc || v4 !== e.v || c4 !== e.c) begin
            miscompares++;
            $display("FAIL pulse4 got cycle=%0d value=%b count=%0d want cycle=%0d value=%b count=%0d",
                     cyc, v4, c4, e.cyc, e.v, e.c);
          end
        end
      end
      if (p8) begin
        vectors++;
        if (exp8.size() == 0) begin
          miscompares++;
          $display("FAIL pulse8_unexpected cycle=%0d value=%b count=%0d", cyc, v8, c8);
        end else begin
          e = exp8.pop_front();
          if (cyc !== e.cyc || v8 !== e.v || c8 !== e.c) begin
            miscompares++;
            $display("FAIL pulse8 got cycle=%0d value=%b count=%0d want cycle=%0d value=%b count=%0d",
                     cyc, v8, c8, e.cyc, e.v, e.c);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    #1;
    rst_n4 = 1'b0;
    rst_n8 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      btn4 = 1'($urandom_range(0, 1));
      btn8 = 1'($urandom_range(0, 1));
      @(negedge clk);
      vectors++;
      if ({v4, p4, c4, v8, p8, c8} !== 12'b0) begin
        miscompares++;
        $display("FAIL reset_hold got %b want 0", {v4, p4, c4, v8, p8, c8});
      end
    end
    btn4 = 1'b0;
    btn8 = 1'b0;
    tick(1);
    rst_n4 = 1'b1;
    rst_n8 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      vectors++;
      if ({v4, p4, c4, v8, p8, c8} !== 12'b0) begin
        miscompares++;
        $display("FAIL reset_release got %b want 0", {v4, p4, c4, v8, p8, c8});
      end
    end
  endtask

  task automatic test_glitch();
    tick(1);
    btn4 = 1'b1;
    tick(4);
    btn4 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      vectors++;
      if (v4 !== 1'b0 || c4 !== 4'd0) begin
        miscompares++;
        $display("FAIL glitch got value=%b count=%0d want value=0 count=0", v4, c4);
      end
    end
  endtask

  task automatic test_clean_press();
    int d;
    tick(1);
    d = cyc;
    btn4 = 1'b1;
    exp4.push_back('{d + 7, 1'b1, 4'd1});
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      vectors++;
      if (v4 !== (cyc >= d + 7)) begin
        miscompares++;
        $display("FAIL press_value cycle=%0d got %b want %b", cyc - d, v4, cyc >= d + 7);
      end
    end
    tick(1);
    btn4 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      vectors++;
      if (v4 !== 1'b1 || c4 !== 4'd1) begin
        miscompares++;
        $display("FAIL release_nochange got value=%b count=%0d want value=1 count=1", v4, c4);
      end
    end
  endtask

  task automatic test_release_bounce();
    int d;
    tick(1);
    d = cyc;
    btn4 = 1'b1;
    exp4.push_back('{d + 7, 1'b0, 4'd2});
    tick(20);
    for (int i = 0; i < 10; i++) begin
      btn4 = ~btn4;
      tick(2);
    end
    btn4 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      vectors++;
      if (v4 !== 1'b0 || c4 !== 4'd2) begin
        miscompares++;
        $display("FAIL bounce got value=%b count=%0d want value=0 count=2", v4, c4);
      end
    end
    tick(1);
    btn4 = 1'b0;
    tick(20);
  endtask

  task automatic test_wrap();
    int d, p0;
    rst_n4 = 1'b0;
    @(negedge clk);
    vectors++;
    if ({v4, p4, c4} !== 6'b0) begin
      miscompares++;
      $display("FAIL wrap_reset got %b want 0", {v4, p4, c4});
    end
    tick(2);
    rst_n4 = 1'b1;
    p0 = pulses4;
    for (int k = 1; k <= 17; k++) begin
      tick(1);
      d = cyc;
      btn4 = 1'b1;
      exp4.push_back('{d + 7, k[0], 4'(k)});
      tick(10);
      btn4 = 1'b0;
      tick(10);
    end
    @(negedge clk);
    vectors++;
    if (pulses4 - p0 !== 17 || v4 !== 1'b1 || c4 !== 4'd1) begin
      miscompares++;
      $display("FAIL wrap got pulses=%0d value=%b count=%0d want pulses=17 value=1 count=1",
               pulses4 - p0, v4, c4);
    end
  endtask

  task automatic test_reset_mid_count();
    int d;
    tick(1);
    d = cyc;
    btn8 = 1'b1;
    exp8.push_back('{d + 11, 1'b1, 4'd1});
    tick(20);
    btn8 = 1'b0;
    tick(20);
    vectors++;
    if (v8 !== 1'b1 || c8 !== 4'd1) begin
      miscompares++;
      $display("FAIL n8_press got value=%b count=%0d want value=1 count=1", v8, c8);
    end
    d = cyc;
    btn8 = 1'b1;
    tick(8);
    rst_n8 = 1'b0;
    #1;
    vectors++;
    if ({v8, p8, c8} !== 6'b0) begin
      miscompares++;
      $display("FAIL async_reset got %b want 0", {v8, p8, c8});
    end
    tick(3);
    d = cyc;
    rst_n8 = 1'b1;
    exp8.push_back('{d + 11, 1'b1, 4'd1});
    tick(20);
    vectors++;
    if (v8 !== 1'b1 || c8 !== 4'd1) begin
      miscompares++;
      $display("FAIL held_through_reset got value=%b count=%0d want value=1 count=1", v8, c8);
    end
    btn8 = 1'b0;
    tick(20);
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_glitch();
    test_clean_press();
    test_release_bounce();
    test_wrap();
    test_reset_mid_count();
    vectors++;
    if (exp4.size() !== 0 || exp8.size() !== 0) begin
      miscompares++;
      $display("FAIL missing_pulses got pending4=%0d pending8=%0d want 0", exp4.size(), exp8.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/button_toggle.md
# button_toggle

Debounced push-button toggle that generates the one-bit `value` select consumed directly by the board's seven-segment driver: `value`=0 displays "5", `value`=1 displays "7". The block synchronises a raw mechanical button and filters bounce with a counter-based state machine. Each accepted press toggles `value` once and emits a one-cycle pulse. A wrapping press counter is provided for debug LEDs.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable synchronised samples required to accept a press or a release (10 ms at 50 MHz); legal range >= 2.
- `CNT_W`, default 20: debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES-1.
- `clk`, in, 1: system clock; all state on rising edge.
- `rst_n`, in, 1: one clock; reset is asynchronous and active-low.
- `btn_in`, in, 1: raw button, active-high, asynchronous to `clk`, bouncy.
- `value`, out, 1: toggle state, registered; feeds the display driver select.
- `press_pulse`, out, 1: high for exactly one cycle on each accepted press.
- `press_count`, out, 4: accepted presses modulo 16.

## Operation
- Synchroniser: two flops, `btn_in` -> s1 -> s2; `btn_s` = s2. FSM and counter use only `btn_s`.
- FSM states: IDLE (released, stable), PRESS_WAIT, HELD (pressed, stable), RELEASE_WAIT.
- IDLE: `btn_s`=1 -> PRESS_WAIT, cnt <= 0; else stay.
- PRESS_WAIT: `btn_s`=0 -> IDLE, cnt <= 0, no toggle. `btn_s`=1 and cnt == DEBOUNCE_CYCLES-1 -> HELD. On that transition: `value` <= ~`value`, `press_pulse` <= 1, `press_count` <= `press_count`+1. Otherwise cnt <= cnt+1.
- HELD: `btn_s`=0 -> RELEASE_WAIT, cnt <= 0; else stay. A stuck-high button gives exactly one toggle.
- RELEASE_WAIT: `btn_s`=1 -> HELD, cnt <= 0. `btn_s`=0 and cnt == DEBOUNCE_CYCLES-1 -> IDLE. Otherwise cnt <= cnt+1. Release never toggles and never pulses.
- `press_count` wraps 15 -> 0 with no flag. Arithmetic is 4-bit unsigned, carry discarded.
- `press_pulse` is cleared in every cycle except the HELD-entry cycle.
- Reset (async assert, any state, including mid-count): state IDLE, cnt 0, s1/s2 0, `value` 0, `press_pulse` 0, `press_count` 0. Release of reset is synchronous to `clk`.
- If the button is held through reset deassertion, the rising `btn_s` after reset counts as a new press and toggles normally.
- cnt is "don't care" in IDLE/HELD; it must not advance there.

## Timing
- Edge 1 is the first rising edge that samples `btn_in`=1. Then: edge 2 gives `btn_s`=1; edge 3 gives IDLE -> PRESS_WAIT.
- Press acceptance needs N = DEBOUNCE_CYCLES high samples in PRESS_WAIT (edges 4..N+3). `value` toggles and `press_pulse` rises after edge N+3, and `press_pulse` falls after edge N+4.
- Minimum accepted press: `btn_in` high for N+1 consecutive edges (edges 3..N+3). Any low sample before acceptance aborts the press.
- Release acceptance: N consecutive low samples in RELEASE_WAIT. With `btn_in` low from edge R, RELEASE_WAIT is entered after edge R+2 and IDLE after edge R+2+N.
- The next press can begin sampling in the cycle after IDLE is reached.
- All outputs are registered; there is no combinational path from `btn_in` to any output.

## Test plan
- Reset: drive `rst_n`=0 with `btn_in` toggling randomly -> `value`=0, `press_pulse`=0, `press_count`=0 throughout. Then deassert with `btn_in`=0 -> outputs hold 0.
- Clean press, N=4: `btn_in` high at edge 1, held 20 cycles -> `value` 0->1 after edge 7, `press_pulse` high only during cycle 7->8, `press_count`=1. Release for 20 cycles -> no change.
- Glitch, N=4: `btn_in` high for 4 edges then low -> no toggle, no pulse, `press_count`=0. FSM returns to IDLE.
- Release bounce, N=4: after an accepted press, toggle `btn_in` low/high every 2 cycles for 20 cycles, then hold high -> `value` unchanged. No second pulse.
- Wrap: 17 clean presses -> `value` ends 1, exactly 17 single-cycle pulses seen, `press_count` sequence ...14,15,0,1.
- Reset mid-count, N=8: assert `rst_n` at PRESS_WAIT cnt=5 with `btn_in` held high -> outputs 0 immediately. After deassert, `value` toggles N+3 edges later, `press_count`=1.
